xpb_table_gen: RTL and testbench



---
 rtl/xpb_pkg.sv | 16 +
 rtl/xpb_mod_add.sv | 23 ++
 rtl/xpb_table_gen.sv | 194 +++++++++++++++++++
 tb/tb_xpb_table_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb reduction-table generator.
package xpb_pkg;

  localparam int unsigned XPB_WIDTH     = 1024;
  localparam int unsigned XPB_ADDR_BITS = 5;
  localparam int unsigned XPB_ENTRIES   = 32;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    EMIT,
    ADD,
    DONE
  } xpb_gen_state_t;

endpackage : xpb_pkg

// File: rtl/xpb_mod_add.sv
// Combinational modular adder: sum_o = (a_i + b_i) mod m_i, valid when a_i, b_i < m_i.
module xpb_mod_add
  import xpb_pkg::*;
#(
  parameter int unsigned WIDTH = XPB_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] sum_o
);

  logic [WIDTH:0] s;
  logic [WIDTH:0] m_ext;

  // One extra bit keeps the carry so the compare against m is exact.
  always_comb begin
    m_ext = {1'b0, m_i};
    s     = {1'b0, a_i} + {1'b0, b_i};
    sum_o = (s >= m_ext) ? WIDTH'(s - m_ext) : WIDTH'(s);
  end

endmodule : xpb_mod_add

// File: rtl/xpb_table_gen.sv
// Writes the 32-entry xpb table, entry j = (j*B) mod M, through a RAM write port.
// Optional build macro XPB_GEN_CHECKSUM_EN adds output chk, the XOR of all
// entries accepted by the RAM in the current run.
module xpb_table_gen
  import xpb_pkg::*;
#(
  parameter int unsigned WIDTH     = XPB_WIDTH,
  parameter int unsigned ADDR_BITS = XPB_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [WIDTH-1:0]     base,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_ready
`ifdef XPB_GEN_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]     chk
`endif
);

  xpb_gen_state_t       state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]     wr_data_q, wr_data_d;
`ifdef XPB_GEN_CHECKSUM_EN
  logic [WIDTH-1:0]     chk_q, chk_d;
`endif

  logic [WIDTH-1:0]     acc_next;
  logic                 in_bad;
  logic                 lat_bad;

  // Single shared adder advances acc by B modulo M.
  xpb_mod_add #(
    .WIDTH (WIDTH)
  ) u_mod_add (
    .a_i   (acc_q),
    .b_i   (b_q),
    .m_i   (m_q),
    .sum_o (acc_next)
  );

  // Operand legality: M must be non-zero and B strictly below M.
  always_comb begin
    in_bad  = (modulus == '0) || (base >= modulus);
    lat_bad = (m_q == '0) || (b_q >= m_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    b_d       = b_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef XPB_GEN_CHECKSUM_EN
    chk_d     = chk_q;
`endif

    unique case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        wr_en_d = 1'b0;
        if (start) begin
          m_d     = modulus;
          b_d     = base;
          acc_d   = '0;
          idx_d   = '0;
          state_d = CHECK;
          // Validity is known from the inputs, so err/busy land in the CHECK cycle.
          if (in_bad) begin
            err_d = 1'b1;
          end else begin
            busy_d = 1'b1;
`ifdef XPB_GEN_CHECKSUM_EN
            chk_d  = '0;
`endif
          end
        end
      end

      CHECK: begin
        if (lat_bad) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = acc_q;
          state_d   = EMIT;
        end
      end

      EMIT: begin
        if (wr_ready) begin
          wr_en_d = 1'b0;
`ifdef XPB_GEN_CHECKSUM_EN
          chk_d   = chk_q ^ wr_data_q;
`endif
          if (&idx_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ADD;
          end
        end
      end

      ADD: begin
        acc_d     = acc_next;
        idx_d     = ADDR_BITS'(idx_q + 1'b1);
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_BITS'(idx_q + 1'b1);
        wr_data_d = acc_next;
        state_d   = EMIT;
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef XPB_GEN_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef XPB_GEN_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
`ifdef XPB_GEN_CHECKSUM_EN
  assign chk     = chk_q;
`endif

endmodule : xpb_table_gen

// File: tb/tb_xpb_table_gen.sv
// Bench for xpb_table_gen: spec-level table/timing model plus directed literals.
module tb_xpb_table_gen;

  localparam int unsigned W  = 1024;
  localparam int unsigned AB = 5;
  localparam int          BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  modulus = '0;
  logic [W-1:0]  base = '0;
  logic          busy, done, err, wr_en;
  logic [AB-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_ready = 1'b1;
`ifdef XPB_GEN_CHECKSUM_EN
  logic [W-1:0]  chk;
`endif

  xpb_table_gen #(.WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .modulus  (modulus),
    .base     (base),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready)
`ifdef XPB_GEN_CHECKSUM_EN
    ,
    .chk      (chk)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Run model state (mode 0: off, 1: valid run, 2: rejected run).
  int           mode = 0;
  int           s_cyc = 0;
  int           nxt = 0;
  int           nidx = 0;
  int           done_rel_m = BIG;
  int           done_obs = -1;
  int           err_obs = -1;
  int           wr_seen = 0;
  bit           fin = 1'b0;
  bit           stall_on = 1'b0;
  logic [W-1:0] exp_tab [32];
  logic [W-1:0] got_tab [32];
  logic [W-1:0] xor_m = '0;

  task automatic chk_v(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (low 128 bits) t=%0t", name, got[127:0], exp[127:0], $time);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // Golden table straight from the definition (j*B) mod M using wide arithmetic.
  task automatic build_model(input logic [W-1:0] m, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    for (int j = 0; j < 32; j++) begin
      prod = (2*W)'(j) * {{W{1'b0}}, b};
      prod = prod % {{W{1'b0}}, m};
      exp_tab[j] = prod[W-1:0];
    end
  endtask

  // Wall-clock: posedge+2 drives wr_ready stalls during cycles 16..18 of a run.
  always @(posedge clk) begin
    #2;
    wr_ready = !(stall_on && (cyc - s_cyc) >= 16 && (cyc - s_cyc) < 19);
  end

  // Compare process: checks every cycle of a run against the spec-level model.
  always @(negedge clk) begin : cmp
    int rel;
    bit exp_en;
    if (!reset && mode != 0) begin
      rel = cyc - s_cyc;
      if (mode == 2) begin
        chk_v("err_pulse", W'(err), W'(rel == 1));
        chk_v("err_busy", W'(busy), '0);
        chk_v("err_wr_en", W'(wr_en), '0);
        chk_v("err_done", W'(done), '0);
        if (err && err_obs < 0) err_obs = rel;
        if (wr_en) wr_seen++;
        if (rel >= 3) fin = 1'b1;
      end else begin
        exp_en = (rel == nxt) && (nidx < 32);
        chk_v("wr_en", W'(wr_en), W'(exp_en));
        if (exp_en) begin
          chk_v("wr_addr", W'(wr_addr), W'(nidx));
          chk_v("wr_data", wr_data, exp_tab[nidx]);
        end
        chk_v("done", W'(done), W'(rel == done_rel_m));
        chk_v("busy", W'(busy), W'(rel >= 1 && rel <= done_rel_m));
        chk_v("err", W'(err), '0);
`ifdef XPB_GEN_CHECKSUM_EN
        if (rel >= 1) chk_v("chk", chk, xor_m);
`endif
        if (done && done_obs < 0) done_obs = rel;
        if (exp_en && wr_ready) begin
          got_tab[nidx] = wr_data;
          xor_m = xor_m ^ exp_tab[nidx];
          if (nidx == 31) done_rel_m = rel + 1;
          nidx++;
          nxt = rel + 2;
        end else if (exp_en) begin
          nxt = rel + 1;
        end
        if (rel == done_rel_m + 1) fin = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [W-1:0] m, input logic [W-1:0] b, input bit valid);
    modulus = m;
    base = b;
    if (valid) build_model(m, b);
    for (int j = 0; j < 32; j++) got_tab[j] = '1;
    s_cyc = cyc;
    nxt = 2;
    nidx = 0;
    done_rel_m = BIG;
    done_obs = -1;
    err_obs = -1;
    wr_seen = 0;
    xor_m = '0;
    fin = 1'b0;
    mode = valid ? 1 : 2;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fin();
    int n;
    n = 0;
    while (!fin && n < 300) begin
      tick();
      n++;
    end
    chk_i("run_finished", int'(fin), 1);
    mode = 0;
    tick();
  endtask

  task automatic wait_addr(input int a);
    int n;
    n = 0;
    while (!(wr_en && int'(wr_addr) == a) && n < 200) begin
      tick();
      n++;
    end
    chk_i("reach_addr", int'(wr_addr), a);
  endtask

  task automatic check_table_a();
    chk_v("tab0", got_tab[0], W'(16'h0000));
    chk_v("tab15", got_tab[15], W'(16'h00F0));
    chk_v("tab16", got_tab[16], W'(16'h0005));
    chk_v("tab31", got_tab[31], W'(16'h00F5));
  endtask

  initial begin
    logic [W-1:0]   m_big;
    logic [W-1:0]   b_big;
    logic [2*W-1:0] p;

    // Reset state.
    repeat (3) tick();
    chk_v("rst_busy", W'(busy), '0);
    chk_v("rst_done", W'(done), '0);
    chk_v("rst_err", W'(err), '0);
    chk_v("rst_wr_en", W'(wr_en), '0);
    chk_v("rst_wr_addr", W'(wr_addr), '0);
    chk_v("rst_wr_data", wr_data, '0);
`ifdef XPB_GEN_CHECKSUM_EN
    chk_v("rst_chk", chk, '0);
`endif
    reset = 1'b0;
    tick();

    // Basic table, wr_ready held high.
    start_run(W'(16'h00FB), W'(16'h0010), 1'b1);
    chk_v("model_e16", exp_tab[16], W'(16'h0005));
    wait_fin();
    check_table_a();
    chk_i("done_cycle", done_obs, 65);

    // Three-cycle stall at address 7.
    stall_on = 1'b1;
    start_run(W'(16'h00FB), W'(16'h0010), 1'b1);
    wait_fin();
    stall_on = 1'b0;
    check_table_a();
    chk_v("stall_tab7", got_tab[7], W'(16'h0070));
    chk_i("stall_done_cycle", done_obs, 68);

    // Rejected: B == M, then M == 0.
    start_run(W'(16'h00FB), W'(16'h00FB), 1'b0);
    wait_fin();
    chk_i("err_cycle_beqm", err_obs, 1);
    chk_i("err_writes_beqm", wr_seen, 0);
    start_run('0, W'(16'h0010), 1'b0);
    wait_fin();
    chk_i("err_cycle_m0", err_obs, 1);
    chk_i("err_writes_m0", wr_seen, 0);

    // Asynchronous reset mid-run at address 10, then a clean rerun.
    start_run(W'(16'h00FB), W'(16'h0010), 1'b1);
    wait_addr(10);
    mode = 0;
    reset = 1'b1;
    #1;
    chk_v("arst_wr_en", W'(wr_en), '0);
    chk_v("arst_busy", W'(busy), '0);
    chk_v("arst_done", W'(done), '0);
    chk_v("arst_wr_data", wr_data, '0);
    tick();
    reset = 1'b0;
    tick();
    start_run(W'(16'h00FB), W'(16'h0010), 1'b1);
    wait_fin();
    check_table_a();

    // Start during a run with changed operands is ignored.
    start_run(W'(16'h00FB), W'(16'h0010), 1'b1);
    wait_addr(5);
    modulus = W'(16'h1234);
    base = W'(16'h0077);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_fin();
    check_table_a();

    // Full-width modulus with carry-out in the adder: B = 2^1030 mod M.
    for (int i = 0; i < 32; i++) m_big[32*i +: 32] = $urandom;
    m_big[W-1] = 1'b1;
    m_big[0] = 1'b1;
    p = '0;
    p[1030] = 1'b1;
    p = p % {{W{1'b0}}, m_big};
    b_big = p[W-1:0];
    start_run(m_big, b_big, 1'b1);
    chk_v("model_big_e0", exp_tab[0], '0);
    chk_v("model_big_e1", exp_tab[1], b_big);
    wait_fin();
    chk_v("big_tab31", got_tab[31], exp_tab[31]);
    chk_i("big_done_cycle", done_obs, 65);
`ifdef XPB_GEN_CHECKSUM_EN
    begin
      logic [W-1:0] x;
      x = '0;
      for (int j = 0; j < 32; j++) x = x ^ exp_tab[j];
      chk_v("chk_final", chk, x);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_xpb_table_gen
